// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional one-entry skid buffer.
// Presents NOP on out_ir whenever empty; flush discards everything held and incoming.
module pipe_stage_skid #(
    parameter int unsigned     PC_W    = 32,
    parameter int unsigned     IR_W    = 32,
    parameter logic [IR_W-1:0] NOP     = IR_W'(32'h2008_0000),
    parameter bit              SKID_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [IR_W-1:0] in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [IR_W-1:0] out_ir,
    output logic [1:0]      count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d;
    logic [IR_W-1:0] main_ir_q, main_ir_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [IR_W-1:0] skid_ir_q, skid_ir_d;
    logic            in_ready_q, in_ready_d;
    logic            accept, take;

    assign out_valid = (state_q != StEmpty);
    assign out_pc    = main_pc_q;
    assign out_ir    = main_ir_q;
    assign count     = state_q;

    // Skid mode registers ready so no combinational path runs back from out_ready.
    assign in_ready = SKID_EN ? in_ready_q : (~out_valid | (out_ready & ~stall));
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready & ~stall;

    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_ir_d = main_ir_q;
        skid_pc_d = skid_pc_q;
        skid_ir_d = skid_ir_q;
        if (flush) begin
            state_d   = StEmpty;
            main_ir_d = NOP;
            skid_pc_d = '0;
            skid_ir_d = NOP;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        main_pc_d = in_pc;
                        main_ir_d = in_ir;
                    end
                end
                StOne: begin
                    if (accept && take) begin
                        main_pc_d = in_pc;
                        main_ir_d = in_ir;
                    end else if (accept) begin
                        state_d   = StFull;
                        skid_pc_d = in_pc;
                        skid_ir_d = in_ir;
                    end else if (take) begin
                        state_d   = StEmpty;
                        main_ir_d = NOP;
                    end
                end
                StFull: begin
                    if (take) begin
                        state_d   = StOne;
                        main_pc_d = skid_pc_q;
                        main_ir_d = skid_ir_q;
                        skid_pc_d = '0;
                        skid_ir_d = NOP;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_pc_q  <= '0;
            main_ir_q  <= NOP;
            skid_pc_q  <= '0;
            skid_ir_q  <= NOP;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_pc_q  <= main_pc_d;
            main_ir_q  <= main_ir_d;
            skid_pc_q  <= skid_pc_d;
            skid_ir_q  <= skid_ir_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid-mode instance checked against a queue model every cycle,
// plus directed checks of a single-register-mode instance.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h2008_0000;

    logic        clock = 1'b0;
    logic        reset, stall, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_ir;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_ir;
    logic [1:0]  count;

    logic        b_stall, b_flush, b_in_valid, b_out_ready;
    logic [31:0] b_in_pc, b_in_ir;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_pc, b_out_ir;
    logic [1:0]  b_count;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [63:0] sbq[$];
    bit          m_ready = 1'b1;

    always #5 clock = ~clock;

    pipe_stage_skid #(.PC_W(32), .IR_W(32), .NOP(NOP), .SKID_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
        .count(count)
    );

    pipe_stage_skid #(.PC_W(32), .IR_W(32), .NOP(NOP), .SKID_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset), .stall(b_stall), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_ir(b_in_ir),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_ir(b_out_ir), .count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare against the model, advance one edge, then update the model.
    task automatic cycle();
        bit acc, tk;
        chk("count", 64'(count), 64'(sbq.size()));
        chk("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        if (sbq.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(sbq[0][63:32]));
            chk("out_ir", 64'(out_ir), 64'(sbq[0][31:0]));
        end else begin
            chk("out_ir_nop", 64'(out_ir), 64'(NOP));
        end
        acc = in_valid && m_ready;
        tk  = (sbq.size() != 0) && out_ready && !stall;
        @(posedge clock);
        #1;
        if (reset || flush) begin
            sbq.delete();
        end else begin
            if (tk) void'(sbq.pop_front());
            if (acc) sbq.push_back({in_pc, in_ir});
        end
        m_ready = (sbq.size() != 2);
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir);
        bit acc0 = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_ir    = ir;
        for (int i = 0; i < 20; i++) begin
            acc0 = m_ready;
            cycle();
            if (acc0) break;
        end
        chk("send_accepted", 64'(acc0), 64'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 32'h4; in_ir = 32'h1111_0000;
        b_stall = 1'b0; b_flush = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        b_in_pc = 32'h4; b_in_ir = 32'h1111_0000;

        // Reset held two cycles with in_valid asserted
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_ir", 64'(out_ir), 64'(NOP));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("rst_b_out_ir", 64'(b_out_ir), 64'(NOP));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
        reset = 1'b0; in_valid = 1'b0; b_in_valid = 1'b0;
        sbq.delete(); m_ready = 1'b1;

        // Single-register mode: combinational in_ready
        b_in_valid = 1'b1; b_in_pc = 32'h100; b_in_ir = 32'hAAAA_0100; b_out_ready = 1'b0;
        @(posedge clock); #1;
        chk("b_valid_after_accept", 64'(b_out_valid), 64'(1));
        chk("b_in_ready_blocked", 64'(b_in_ready), 64'(0));
        b_in_pc = 32'h104; b_in_ir = 32'hAAAA_0104;
        @(posedge clock); #1;
        chk("b_hold_pc", 64'(b_out_pc), 64'(32'h100));
        b_out_ready = 1'b1;
        #1;
        chk("b_in_ready_comb", 64'(b_in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("b_stream_pc", 64'(b_out_pc), 64'(32'h104 + 32'(4 * i)));
            chk("b_stream_ir", 64'(b_out_ir), 64'(32'hAAAA_0104 + 32'(4 * i)));
            chk("b_stream_valid", 64'(b_out_valid), 64'(1));
            b_in_pc = 32'h108 + 32'(4 * i);
            b_in_ir = 32'hAAAA_0108 + 32'(4 * i);
        end
        b_in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("b_drained_valid", 64'(b_out_valid), 64'(0));
        chk("b_drained_ir", 64'(b_out_ir), 64'(NOP));
        chk("b_drained_count", 64'(b_count), 64'(0));

        // Stream four beats at full throughput
        for (int i = 1; i <= 4; i++) send(32'(4 * i), 32'h0100_0000 + 32'(i));
        repeat (3) cycle();

        // Skid fill under stall, then release
        stall = 1'b1;
        send(32'h4, 32'h0200_0004);
        send(32'h8, 32'h0200_0008);
        in_valid = 1'b1; in_pc = 32'hC; in_ir = 32'h0200_000C;
        repeat (2) cycle();
        stall = 1'b0;
        send(32'hC, 32'h0200_000C);
        repeat (3) cycle();

        // Flush beats a same-cycle input and a stalled FULL stage
        stall = 1'b1;
        send(32'h40, 32'h0300_0040);
        send(32'h44, 32'h0300_0044);
        cycle();
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'd20; in_ir = 32'h0300_0014;
        cycle();
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        repeat (3) cycle();

        // Reset together with flush clears out_pc as well
        stall = 1'b1;
        send(32'h80, 32'h0400_0080);
        send(32'h84, 32'h0400_0084);
        reset = 1'b1; flush = 1'b1;
        cycle();
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        chk("rstflush_out_pc", 64'(out_pc), 64'(0));
        repeat (2) cycle();

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = $urandom;
            in_ir     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register: the next-generation replacement for the fixed-width stall/flush stage registers between pipeline stages (IF→ID first, then ID→EX and beyond). It adds a valid bit, a valid/ready handshake with an optional one-entry skid buffer, NOP bubble injection, flush with priority, and an occupancy output. Upstream can then keep fetching while downstream stalls, with no combinational ready path when the skid is enabled.

## Interface
- PC_W, 32, width of PC payload field
- IR_W, 32, width of instruction payload field
- NOP, 32'h20080000 (addi $t0,$zero,0), instruction presented on out_ir whenever out_valid=0; width IR_W
- SKID_EN, 1, 1 = two-entry skid mode (registered in_ready); 0 = single-register mode (combinational in_ready)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold request from hazard unit; blocks output transfer
- flush  in  1  discard all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_pc  in  PC_W  upstream PC+4
- in_ir  in  IR_W  upstream instruction
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  held PC
- out_ir  out  IR_W  held instruction; NOP when out_valid=0
- count  out  2  occupancy: 0, 1 or 2

## Operation
- accept = in_valid & in_ready; take = out_valid & out_ready & ~stall.
- States: EMPTY (count 0), ONE (main full), FULL (main + skid full; SKID_EN=1 only).
- EMPTY: accept → ONE, main ← in.
- ONE:
  - accept & take → ONE, main ← in.
  - accept & ~take → FULL, skid ← in.
  - ~accept & take → EMPTY.
  - otherwise hold.
- FULL: take → ONE, main ← skid. No accept is possible because in_ready=0.
- flush (any state) → EMPTY. Skid is cleared, the same-cycle input beat is discarded, and out_ir ← NOP. flush has priority over accept, take and stall.
- Entering EMPTY loads out_ir ← NOP. out_pc holds its last value, because it is meaningless when invalid.
- SKID_EN=1: in_ready is registered and equals (next state ≠ FULL).
- SKID_EN=0: FULL is unreachable. in_ready = ~out_valid | (out_ready & ~stall), combinational. ONE with accept & ~take cannot occur.
- stall and ~out_ready are equivalent for transfer purposes. Beats are never dropped or duplicated except on flush.
- Payload is passed bit-exact. No arithmetic is performed.

## Timing
- Reset values: out_valid=0, out_ir=NOP, out_pc=0, count=0, skid empty, in_ready=1 (both modes).
- Latency is 1 cycle from accept to out_valid, whether entering an empty stage or one draining in the same cycle.
- Throughput is 1 beat/cycle with out_ready=1 and stall=0.
- In SKID_EN=1 mode, in_ready falls in the cycle after FULL is entered. It rises in the cycle after the first take from FULL.
- Order is preserved: main always holds the older beat and skid the younger.
- Flush takes effect at the edge where it is sampled. The next cycle shows out_valid=0, count=0 and in_ready=1.
- reset and flush asserted together: reset wins, but the results are identical except that out_pc is forced to 0.
- Reset mid-stream: all held beats are discarded. There are no X values on any output after the first edge with reset=1.

## Test plan
- Reset: hold reset for 2 cycles with in_valid=1 → out_valid=0, out_ir=32'h20080000, out_pc=0, count=0, in_ready=1.
- Stream: 4 beats with pc=4,8,12,16, out_ready=1, stall=0 → same pcs appear 1 cycle later, back-to-back, count stays 1.
- Skid fill (SKID_EN=1): stall=1 while beats pc=4,8,12 are offered → 4 in main, 8 in skid, in_ready=0, 12 held upstream, count=2. Release stall → 4, 8, 12 emerge on consecutive cycles.
- Flush priority: FULL with stall=1, then flush=1 and in_valid=1 (pc=20) in the same cycle → next cycle out_valid=0, out_ir=NOP, count=0, and pc=20 never appears.
- Single-register mode (SKID_EN=0): out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. Set out_ready=1 → in_ready=1 combinationally and pass-through continues at 1 beat/cycle.
- Random: random in_valid, out_ready, stall and sparse flush over 10k cycles, checked against a queue scoreboard → no loss, duplication or reordering between flushes, and count always matches the scoreboard occupancy.
